// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Brief   : Widths, word type and sizing helper shared by the 16->32 packer.
// Rev     : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_buf_sync.sv
`default_nettype none
// ============================================================================
// Module  : ring_buf_sync
// Brief   : Synchronous ring buffer with wrapping pointers and occupancy count.
// Rev     : 1.0  initial release
// ============================================================================
module ring_buf_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo16to32.sv
`default_nettype none
// ============================================================================
// Module  : fifo16to32
// Brief   : Packs pairs of 16-bit half-words (first half high) into a 32-bit FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module fifo16to32
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HALF_W-1:0] data_in,
    input  logic              data_in_vld,
    output logic              data_in_rdy,
    output logic [WORD_W-1:0] data_out,
    output logic              data_out_vld,
    input  logic              data_out_rdy,
    output logic              partial
);

    localparam int CNT_W = clog2_depth(DEPTH);

    logic [HALF_W-1:0] r_hi;
    logic              r_partial;
    word_t             w_rd_data;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_wr_en;
    logic              w_pop;

    // A first half only needs the staging register, so it is taken even when storage is full.
    assign data_in_rdy  = !r_partial || !w_full;
    assign w_accept     = data_in_vld && data_in_rdy;
    assign w_wr_en      = w_accept && r_partial;
    assign data_out_vld = !w_empty;
    assign w_pop        = data_out_vld && data_out_rdy;
    assign data_out     = (w_count != '0) ? w_rd_data : '0;
    assign partial      = r_partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= '0;
            r_partial <= 1'b0;
        end else if (w_accept) begin
            if (!r_partial) begin
                r_hi      <= data_in;
                r_partial <= 1'b1;
            end else begin
                r_partial <= 1'b0;
            end
        end
    end

    ring_buf_sync #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data ({r_hi, data_in}),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule
`default_nettype wire
